// File: rtl/conv_pkg.sv
// Constants shared by the window generator and the convolution unit:
// operand width default and 3x3 window packing.
package conv_pkg;

  localparam int unsigned DefDw   = 17;
  localparam int unsigned WinRows = 3;
  localparam int unsigned WinCols = 3;
  localparam int unsigned WinSize = WinRows * WinCols;

  // Element k of a packed window sits at [DW*k +: DW], row-major, k=0 is top-left (oldest).
  function automatic int unsigned win_idx(input int unsigned r, input int unsigned c);
    return r * WinCols + c;
  endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out handshake bundle for conv_window_gen.
interface conv_window_gen_if
  import conv_pkg::*;
#(
  parameter int unsigned DW = DefDw
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DW-1:0]         in_data;
  logic                  win_valid;
  logic                  win_ready;
  logic [WinSize*DW-1:0] win_data;
  logic                  win_last;

  // master: pixel producer plus window consumer; slave: the window generator
  modport master (
    output in_valid, in_data, win_ready,
    input  in_ready, win_valid, win_data, win_last
  );

  modport slave (
    input  in_valid, in_data, win_ready,
    output in_ready, win_valid, win_data, win_last
  );

endinterface

// File: rtl/conv_line_buf.sv
// Line buffer: DEPTH-deep circular FIFO; dout is the word written DEPTH enables ago.
module conv_line_buf
  import conv_pkg::*;
#(
  parameter int unsigned DW    = DefDw,
  parameter int unsigned DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  localparam int unsigned     PW      = $clog2(DEPTH);
  localparam logic [PW-1:0]   PtrLast = PW'(DEPTH - 1);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;

  assign dout = mem[ptr_q];

  always_comb begin
    ptr_d = ptr_q;
    if (en) begin
      ptr_d = (ptr_q == PtrLast) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Storage is deliberately not reset; stale rows are overwritten before any window uses them.
  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr_q] <= din;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// 3x3 sliding-window generator for raster pixel streams (valid convolution, no padding).
// Optional frame counter output enabled by defining CONV_WINDOW_GEN_FRAME_CNT_EN.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int unsigned DW    = DefDw,
  parameter int unsigned IMG_W = 8,
  parameter int unsigned IMG_H = 8
) (
  input  logic             clk,
  input  logic             rst,
`ifdef CONV_WINDOW_GEN_FRAME_CNT_EN
  output logic [15:0]      frame_cnt,
`endif
  conv_window_gen_if.slave bus
);

  localparam int unsigned   CW      = $clog2(IMG_W);
  localparam int unsigned   RW      = $clog2(IMG_H);
  localparam logic [CW-1:0] ColLast = CW'(IMG_W - 1);
  localparam logic [RW-1:0] RowLast = RW'(IMG_H - 1);

  logic                  accept, load;
  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [DW-1:0]         lb0_out, lb1_out;
  logic [DW-1:0]         col_in [WinRows];
  logic [DW-1:0]         win_q  [WinSize];
  logic [DW-1:0]         win_d  [WinSize];
  logic                  win_valid_q, win_valid_d;
  logic                  win_last_q, win_last_d;
  logic [WinSize*DW-1:0] win_data_q, win_data_d;

  assign bus.in_ready  = !win_valid_q || bus.win_ready;
  assign bus.win_valid = win_valid_q;
  assign bus.win_last  = win_last_q;
  assign bus.win_data  = win_data_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign load   = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));

  conv_line_buf #(.DW(DW), .DEPTH(IMG_W)) u_lb0 (
    .clk  (clk),
    .rst  (rst),
    .en   (accept),
    .din  (bus.in_data),
    .dout (lb0_out)
  );

  conv_line_buf #(.DW(DW), .DEPTH(IMG_W)) u_lb1 (
    .clk  (clk),
    .rst  (rst),
    .en   (accept),
    .din  (lb0_out),
    .dout (lb1_out)
  );

  // New right-hand column: two rows up, one row up, current pixel.
  assign col_in[0] = lb1_out;
  assign col_in[1] = lb0_out;
  assign col_in[2] = bus.in_data;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_q == ColLast) begin
        col_d = '0;
        row_d = (row_q == RowLast) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int unsigned r = 0; r < WinRows; r++) begin
        for (int unsigned c = 0; c < WinCols - 1; c++) begin
          win_d[win_idx(r, c)] = win_q[win_idx(r, c + 1)];
        end
        win_d[win_idx(r, WinCols - 1)] = col_in[r];
      end
    end
  end

  always_comb begin
    win_valid_d = win_valid_q;
    win_last_d  = win_last_q;
    win_data_d  = win_data_q;
    if (load) begin
      win_valid_d = 1'b1;
      win_last_d  = (row_q == RowLast) && (col_q == ColLast);
      for (int unsigned k = 0; k < WinSize; k++) begin
        win_data_d[k*DW +: DW] = win_d[k];
      end
    end else if (bus.win_ready) begin
      win_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      win_data_q  <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
      win_data_q  <= win_data_d;
    end
  end

  always_ff @(posedge clk) begin
    win_q <= win_d;
  end

`ifdef CONV_WINDOW_GEN_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (win_valid_q && bus.win_ready && win_last_q) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule
